// File: rtl/vga_ctrl_gen2.sv
// Parametrised VGA timing generator with VRAM fetch, latency-matched alignment
// pipeline, frame-locked test patterns and registered DAC outputs.
module vga_ctrl_gen2 #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned CW       = 4,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic [3*CW-1:0]               fill_rgb,
    input  logic [3*CW-1:0]               d_in,
    output logic [$clog2(V_ACTIVE)-1:0]   row_addr,
    output logic [$clog2(H_ACTIVE)-1:0]   col_addr,
    output logic                          rdn,
    output logic [CW-1:0]                 r,
    output logic [CW-1:0]                 g,
    output logic [CW-1:0]                 b,
    output logic                          hs,
    output logic                          vs,
    output logic                          de,
    output logic                          frame_start,
    output logic                          line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters keep at least 6 bits so the checkerboard can always use bit 5.
    localparam int unsigned HW      = ($clog2(H_TOTAL) > 6) ? $clog2(H_TOTAL) : 6;
    localparam int unsigned VW      = ($clog2(V_TOTAL) > 6) ? $clog2(V_TOTAL) : 6;
    localparam int unsigned RAW     = $clog2(V_ACTIVE);
    localparam int unsigned CAW     = $clog2(H_ACTIVE);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BW      = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;
    localparam logic        HS_ON   = (HS_POL != 0);
    localparam logic        VS_ON   = (VS_POL != 0);

    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       ls;
        logic       fs;
        logic [1:0] mode;
        logic [2:0] bar;
        logic       chk;
    } stage_t;

    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [1:0]      mode_q;
    logic [BW-1:0]   bar_pix;
    logic [2:0]      bar_idx;
    logic            h_act;
    logic            v_act;
    logic            origin;
    stage_t          fetch;
    stage_t          algn;
    logic [3*CW-1:0] pix_c;

    assign h_act  = 32'(h_cnt) < H_ACTIVE;
    assign v_act  = 32'(v_cnt) < V_ACTIVE;
    assign origin = (h_cnt == '0) && (v_cnt == '0);

    // Raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Mode is frame-locked: sampled only at the first pixel slot of a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 2'd0;
        end else if (origin) begin
            mode_q <= mode;
        end
    end

    // Per-line bar index, advanced by a pixel counter instead of dividing h_cnt
    always_ff @(posedge clk) begin
        if (rst || (h_cnt == HW'(H_TOTAL - 1))) begin
            bar_pix <= '0;
            bar_idx <= 3'd0;
        end else if (h_act) begin
            if (bar_pix == BW'(BAR_W - 1)) begin
                bar_pix <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pix <= bar_pix + BW'(1);
            end
        end
    end

    // Fetch-stage flags and pattern inputs
    always_comb begin
        fetch        = '0;
        fetch.active = h_act && v_act;
        fetch.hsync  = (32'(h_cnt) >= H_ACTIVE + H_FP) &&
                       (32'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
        fetch.vsync  = (32'(v_cnt) >= V_ACTIVE + V_FP) &&
                       (32'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
        fetch.ls     = h_act && v_act && (h_cnt == '0);
        fetch.fs     = h_act && v_act && origin;
        fetch.mode   = origin ? mode : mode_q;
        fetch.bar    = bar_idx;
        fetch.chk    = h_cnt[5] ^ v_cnt[5];
    end

    assign rdn      = ~fetch.active;
    assign row_addr = fetch.active ? v_cnt[RAW-1:0] : '0;
    assign col_addr = fetch.active ? h_cnt[CAW-1:0] : '0;

    // Delay line matching the VRAM read latency
    generate
        if (RD_LAT == 0) begin : g_nolat
            assign algn = fetch;
        end else begin : g_lat
            stage_t pipe_q [RD_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= fetch;
                    for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign algn = pipe_q[RD_LAT-1];
        end
    endgenerate

    // Pixel source select; blanking forces black
    always_comb begin
        pix_c = '0;
        case (algn.mode)
            2'd0:    pix_c = d_in;
            2'd1:    pix_c = {{CW{~algn.bar[1]}}, {CW{~algn.bar[2]}}, {CW{~algn.bar[0]}}};
            2'd2:    pix_c = fill_rgb;
            default: pix_c = algn.chk ? '1 : '0;
        endcase
        if (!algn.active) pix_c = '0;
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de          <= 1'b0;
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            {r, g, b}   <= pix_c;
            de          <= algn.active;
            hs          <= algn.hsync ? HS_ON : ~HS_ON;
            vs          <= algn.vsync ? VS_ON : ~VS_ON;
            frame_start <= algn.fs;
            line_start  <= algn.ls;
        end
    end

endmodule

// File: tb/tb_vga_ctrl_gen2.sv
// Bench for vga_ctrl_gen2: default-timing DUT (RD_LAT=1) plus two tiny-timing DUTs
// (RD_LAT=0 and 4, active-high hsync), all checked each cycle against a raster model.
module tb_vga_ctrl_gen2;

    localparam int P_HA   [3] = '{640, 8, 8};
    localparam int P_HF   [3] = '{16, 2, 2};
    localparam int P_HS   [3] = '{96, 2, 2};
    localparam int P_HB   [3] = '{48, 2, 2};
    localparam int P_VA   [3] = '{480, 4, 4};
    localparam int P_VF   [3] = '{10, 1, 1};
    localparam int P_VS   [3] = '{2, 1, 1};
    localparam int P_VB   [3] = '{33, 1, 1};
    localparam int P_HPOL [3] = '{0, 1, 1};
    localparam int P_LAT  [3] = '{1, 0, 4};
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [11:0] fill_rgb;

    logic [11:0] din_a, din_0, din_4;
    logic [8:0]  row_a;
    logic [9:0]  col_a;
    logic [1:0]  row_0, row_4;
    logic [2:0]  col_0, col_4;
    logic        rdn_a, rdn_0, rdn_4;
    logic [3:0]  r_a, g_a, b_a, r_0, g_0, b_0, r_4, g_4, b_4;
    logic        hs_a, vs_a, de_a, fs_a, ls_a;
    logic        hs_0, vs_0, de_0, fs_0, ls_0;
    logic        hs_4, vs_4, de_4, fs_4, ls_4;

    int          n_cnt [3];
    logic [1:0]  fmode [3][2];
    logic [11:0] fill_prev;
    logic [11:0] q_a [$];
    logic [11:0] q_0 [$];
    logic [11:0] q_4 [$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    vga_ctrl_gen2 #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .fill_rgb(fill_rgb), .d_in(din_a),
        .row_addr(row_a), .col_addr(col_a), .rdn(rdn_a), .r(r_a), .g(g_a), .b(b_a),
        .hs(hs_a), .vs(vs_a), .de(de_a), .frame_start(fs_a), .line_start(ls_a));

    vga_ctrl_gen2 #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(1), .V_BP(1), .HS_POL(1), .RD_LAT(0)) dut_0 (
        .clk(clk), .rst(rst), .mode(mode), .fill_rgb(fill_rgb), .d_in(din_0),
        .row_addr(row_0), .col_addr(col_0), .rdn(rdn_0), .r(r_0), .g(g_0), .b(b_0),
        .hs(hs_0), .vs(vs_0), .de(de_0), .frame_start(fs_0), .line_start(ls_0));

    vga_ctrl_gen2 #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(1), .V_BP(1), .HS_POL(1), .RD_LAT(4)) dut_4 (
        .clk(clk), .rst(rst), .mode(mode), .fill_rgb(fill_rgb), .d_in(din_4),
        .row_addr(row_4), .col_addr(col_4), .rdn(rdn_4), .r(r_4), .g(g_4), .b(b_4),
        .hs(hs_4), .vs(vs_4), .de(de_4), .frame_start(fs_4), .line_start(ls_4));

    function automatic logic [11:0] vram(input int col, input int row);
        return {4'(col), 4'(row), 4'hA};
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d period=%0d got=%0h expected=%0h", tag, d, n_cnt[d], obs, exp);
        end
    endtask

    // Expected outputs from raster position: fetch at period n, pins show period n-LAT-1
    task automatic check_dut(input int d, input logic [11:0] rgb_o, input logic hs_o,
                             input logic vs_o, input logic de_o, input logic fs_o,
                             input logic ls_o, input logic rdn_o,
                             input logic [31:0] row_o, input logic [31:0] col_o);
        int ht, vt, ft, n, h, v, k, hk, vk;
        logic act, ede, ehs, evs;
        logic [11:0] ergb;
        ht = P_HA[d] + P_HF[d] + P_HS[d] + P_HB[d];
        vt = P_VA[d] + P_VF[d] + P_VS[d] + P_VB[d];
        ft = ht * vt;
        n  = n_cnt[d];
        h  = n % ht;
        v  = (n / ht) % vt;
        act = (h < P_HA[d]) && (v < P_VA[d]);
        chk("rdn", d, 32'(rdn_o), 32'(!act));
        chk("row_addr", d, row_o, 32'(act ? v : 0));
        chk("col_addr", d, col_o, 32'(act ? h : 0));
        k = n - P_LAT[d] - 1;
        hk = 0; vk = 0; ede = 1'b0; ehs = 1'b0; evs = 1'b0; ergb = 12'h000;
        if (k >= 0) begin
            hk  = k % ht;
            vk  = (k / ht) % vt;
            ede = (hk < P_HA[d]) && (vk < P_VA[d]);
            ehs = (hk >= P_HA[d] + P_HF[d]) && (hk < P_HA[d] + P_HF[d] + P_HS[d]);
            evs = (vk >= P_VA[d] + P_VF[d]) && (vk < P_VA[d] + P_VF[d] + P_VS[d]);
            if (ede) begin
                case (fmode[d][(k / ft) % 2])
                    2'd0:    ergb = vram(hk, vk);
                    2'd1:    ergb = BARS[hk / (P_HA[d] / 8)];
                    2'd2:    ergb = fill_prev;
                    default: ergb = ((((hk >> 5) ^ (vk >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
                endcase
            end
        end
        chk("de", d, 32'(de_o), 32'(ede));
        chk("hs", d, 32'(hs_o), 32'(ehs ? P_HPOL[d] : 1 - P_HPOL[d]));
        chk("vs", d, 32'(vs_o), 32'(evs ? 0 : 1));
        chk("frame_start", d, 32'(fs_o), 32'(ede && hk == 0 && vk == 0));
        chk("line_start", d, 32'(ls_o), 32'(ede && hk == 0));
        chk("rgb", d, 32'(rgb_o), 32'(ergb));
    endtask

    // One pixel period: count the edge, drive inputs, serve VRAM, check at negedge
    task automatic step(input logic rv, input logic [1:0] mv, input logic [11:0] fv);
        int ft;
        @(posedge clk);
        for (int d = 0; d < 3; d++) n_cnt[d] = rst ? 0 : n_cnt[d] + 1;
        fill_prev = fill_rgb;
        #1;
        rst = rv; mode = mv; fill_rgb = fv;
        for (int d = 0; d < 3; d++) begin
            ft = (P_HA[d] + P_HF[d] + P_HS[d] + P_HB[d]) * (P_VA[d] + P_VF[d] + P_VS[d] + P_VB[d]);
            if (n_cnt[d] % ft == 0) fmode[d][(n_cnt[d] / ft) % 2] = mv;
        end
        q_a.push_back(rdn_a ? 12'h000 : vram(int'(col_a), int'(row_a)));
        q_0.push_back(rdn_0 ? 12'h000 : vram(int'(col_0), int'(row_0)));
        q_4.push_back(rdn_4 ? 12'h000 : vram(int'(col_4), int'(row_4)));
        if (q_a.size() > 1) din_a = q_a.pop_front();
        if (q_0.size() > 0) din_0 = q_0.pop_front();
        if (q_4.size() > 4) din_4 = q_4.pop_front();
        @(negedge clk);
        check_dut(0, {r_a, g_a, b_a}, hs_a, vs_a, de_a, fs_a, ls_a, rdn_a, 32'(row_a), 32'(col_a));
        check_dut(1, {r_0, g_0, b_0}, hs_0, vs_0, de_0, fs_0, ls_0, rdn_0, 32'(row_0), 32'(col_0));
        check_dut(2, {r_4, g_4, b_4}, hs_4, vs_4, de_4, fs_4, ls_4, rdn_4, 32'(row_4), 32'(col_4));
    endtask

    task automatic run_rand(input int cycles);
        logic [1:0]  m;
        logic [11:0] f;
        for (int i = 0; i < cycles; i++) begin
            m = mode;
            f = fill_rgb;
            if ($urandom_range(0, 39) == 0) m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) f = 12'($urandom);
            step(1'b0, m, f);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; fill_rgb = 12'h000; fill_prev = 12'h000;
        din_a = 12'h000; din_0 = 12'h000; din_4 = 12'h000;
        for (int d = 0; d < 3; d++) begin
            n_cnt[d] = 0;
            fmode[d][0] = 2'd0;
            fmode[d][1] = 2'd0;
        end

        // Reset held for five periods
        repeat (5) step(1'b1, 2'd0, 12'h000);

        // Frame-buffer frame on the default DUT; small DUTs see random mode churn
        step(1'b0, 2'd0, 12'h000);
        run_rand(2500);

        // Colour bars frame
        step(1'b1, 2'd0, 12'h000);
        step(1'b1, 2'd0, 12'h000);
        step(1'b0, 2'd1, 12'h000);
        run_rand(900 + int'($urandom_range(0, 40)));

        // Single-cycle reset mid-line, then checkerboard through rows 31/32
        step(1'b1, mode, fill_rgb);
        step(1'b0, 2'd3, fill_rgb);
        run_rand(26500);

        // Solid fill frame with fill colour changing underneath
        step(1'b1, 2'd0, 12'h000);
        step(1'b0, 2'd2, 12'h5A3);
        run_rand(1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
